// File: rtl/serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor that adds CHUNK bits per clock,
// least-significant chunk first, with valid/ready handshakes on both sides.
module serial_addsub #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtr,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(WIDTH);

  generate
    if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
      $error("serial_addsub: WIDTH must be >= 2 and an exact multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             overflow_r;
  logic             zero_r;
  logic             negative_r;

  logic [BW-1:0]    base_s;
  logic [CHUNK-1:0] a_chunk_s;
  logic [CHUNK-1:0] b_chunk_s;
  logic [CHUNK:0]   chunk_sum_s;
  logic [WIDTH-1:0] acc_next_s;
  logic             carry_in_msb_s;
  logic             last_s;

  assign base_s      = BW'(count_r) * BW'(CHUNK);
  assign a_chunk_s   = a_r[base_s +: CHUNK];
  assign b_chunk_s   = b_r[base_s +: CHUNK];
  assign chunk_sum_s = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
  // A sum bit is a ^ b ^ cin, so the carry into the top bit falls out of the chunk MSBs.
  assign carry_in_msb_s = a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1] ^ chunk_sum_s[CHUNK-1];
  assign last_s         = (count_r == CW'(N - 1));

  // Accumulator with the current chunk result merged into its slice.
  always_comb begin
    acc_next_s                   = acc_r;
    acc_next_s[base_s +: CHUNK]  = chunk_sum_s[CHUNK-1:0];
  end

  // Control FSM, operand latches, chunk datapath and registered result/flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      count_r    <= {CW{1'b0}};
      carry_r    <= 1'b0;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      acc_r      <= {WIDTH{1'b0}};
      sum_r      <= {WIDTH{1'b0}};
      cout_r     <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
      negative_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            a_r     <= a;
            b_r     <= b ^ {WIDTH{subtr}};
            carry_r <= subtr;
            count_r <= {CW{1'b0}};
            state_r <= RUN;
          end
        end
        RUN: begin
          acc_r   <= acc_next_s;
          carry_r <= chunk_sum_s[CHUNK];
          count_r <= count_r + CW'(1);
          if (last_s) begin
            sum_r      <= acc_next_s;
            cout_r     <= chunk_sum_s[CHUNK];
            overflow_r <= carry_in_msb_s ^ chunk_sum_s[CHUNK];
            zero_r     <= (acc_next_s == {WIDTH{1'b0}});
            negative_r <= acc_next_s[WIDTH-1];
            state_r    <= DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign start_ready  = (state_r == IDLE);
  assign result_valid = (state_r == DONE);
  assign sum          = sum_r;
  assign cout         = cout_r;
  assign overflow     = overflow_r;
  assign zero         = zero_r;
  assign negative     = negative_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=16, CHUNK=4): directed plan
// cases followed by randomized operations against an arithmetic reference.
module tb_serial_addsub;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        subtr = 1'b0;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;
  logic        zero;
  logic        negative;

  int vectors = 0;
  int miscompares = 0;

  serial_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .subtr        (subtr),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum          (sum),
    .cout         (cout),
    .overflow     (overflow),
    .zero         (zero),
    .negative     (negative)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic [15:0] es, input logic ec,
                            input logic ev, input logic ez, input logic en);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_overflow"}, 32'(overflow), 32'(ev));
    chk({tag, "_zero"}, 32'(zero), 32'(ez));
    chk({tag, "_negative"}, 32'(negative), 32'(en));
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic msub,
                                output logic [15:0] rs, output logic rc, output logic rv,
                                output logic rz, output logic rn);
    int ua, ub, r, sa, sb, ex;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    r  = msub ? (ua - ub) : (ua + ub);
    rs = r[15:0];
    rc = msub ? (ua >= ub) : (r > 65535);
    ex = msub ? (sa - sb) : (sa + sb);
    rv = (ex > 32767) || (ex < -32768);
    rz = (rs == 16'h0000);
    rn = rs[15];
  endfunction

  task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic os,
                        input int hold, input logic scramble);
    logic [15:0] es;
    logic        ec, ev, ez, en;
    int          cyc;
    model(oa, ob, os, es, ec, ev, ez, en);
    cyc = 0;
    while (!start_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("start_ready_before_op", 32'(start_ready), 32'd1);
    a = oa;
    b = ob;
    subtr = os;
    result_ready = (hold == 0);
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    chk("start_ready_in_run", 32'(start_ready), 32'd0);
    cyc = 0;
    while (!result_valid && cyc < 20) begin
      if (scramble) begin
        a = 16'($urandom);
        b = 16'($urandom);
        subtr = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(N));
    chk_result("result", es, ec, ev, ez, en);
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_result_valid", 32'(result_valid), 32'd1);
      chk("bp_start_ready", 32'(start_ready), 32'd0);
      chk_result("bp_hold", es, ec, ev, ez, en);
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_start_ready", 32'(start_ready), 32'd1);
    chk("idle_result_valid", 32'(result_valid), 32'd0);
    chk("idle_sum_kept", 32'(sum), 32'(es));
  endtask

  initial begin
    #1;
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk_result("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    #12 reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h0FFF, 1'b0, 0, 1'b0);
    chk("plan_sum_2233", 32'(sum), 32'h0000_2233);
    run_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h1234, 16'h1234, 1'b1, 0, 1'b0);
    run_op(16'hABCD, 16'h1234, 1'b0, 3, 1'b0);
    run_op(16'h4321, 16'h1111, 1'b1, 0, 1'b1);
    run_op(16'hF00F, 16'h0FF1, 1'b1, 0, 1'b0);

    // Abort mid-operation at count == 2.
    a = 16'h00F0;
    b = 16'h0F00;
    subtr = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("abort_start_ready", 32'(start_ready), 32'd1);
    chk("abort_result_valid", 32'(result_valid), 32'd0);
    chk_result("abort", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    run_op(16'h0001, 16'h0002, 1'b0, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
